spi_pwm_host: RTL and testbench

- SPI initiator (master) that drives the 7-channel PWM driver's SPI port (sclk, cs, mosi, miso) from a simple parallel command interface.
- A controller issues one command per transaction:
  - write: set PWM level of channel 0..6;
  - read: fetch the current level.
- The block serialises the command in the exact frame format the driver expects and returns read data.
- Sits on the controller side of the board-level SPI link.

---
 rtl/spi_pwm_host_pkg.sv | 31 +++
 rtl/spi_pwm_host_sync_2ff.sv | 25 ++
 rtl/spi_pwm_host.sv | 180 ++++++++++++++++++
 tb/tb_spi_pwm_host.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pwm_host_pkg.sv
// Shared definitions for the SPI link to the 7-channel PWM driver:
// frame layout constants, pulse counts and the host FSM state type.
package spi_pwm_host_pkg;

    localparam int unsigned SPI_WRITE_FLAG_BIT  = 7;
    localparam int unsigned SPI_ADDR_BITS       = 3;
    localparam int unsigned PWM_NUM_CHANNELS    = 7;
    localparam int unsigned SPI_WR_PULSES       = 16;
    localparam int unsigned SPI_RD_PULSES       = 17;
    localparam int unsigned SPI_RD_FIRST_SAMPLE = 10;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StHigh,
        StLow,
        StGap
    } spi_state_e;

    // 17-bit shift word: byte0, byte1, then the trailing 0 sent on read pulse 17.
    function automatic logic [16:0] build_frame(input logic                     wr,
                                                input logic [SPI_ADDR_BITS-1:0] addr,
                                                input logic [7:0]               wdata);
        logic [7:0] byte0;
        byte0                     = 8'h00;
        byte0[SPI_WRITE_FLAG_BIT] = wr;
        byte0[SPI_ADDR_BITS-1:0]  = addr;
        return {byte0, (wr ? wdata : 8'h00), 1'b0};
    endfunction

endpackage

// File: rtl/spi_pwm_host_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; clears to 0 on
// synchronous active-low reset.
module spi_pwm_host_sync_2ff (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/spi_pwm_host.sv
// SPI initiator for the PWM driver: serialises one write/read command per
// cs frame and returns read data with a one-cycle response pulse.
module spi_pwm_host
    import spi_pwm_host_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned CS_GAP  = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_write,
    input  logic [SPI_ADDR_BITS-1:0] cmd_addr,
    input  logic [7:0]               cmd_wdata,
    output logic                     rsp_valid,
    output logic [7:0]               rsp_rdata,
    output logic                     busy,
    output logic                     sclk,
    output logic                     cs,
    output logic                     mosi,
    input  logic                     miso
);

    localparam logic [7:0] PhaseLast = 8'(CLK_DIV - 1);
    localparam logic [7:0] GapLast   = 8'(CS_GAP - 1);
    localparam logic [4:0] WrPulses  = 5'(SPI_WR_PULSES);
    localparam logic [4:0] RdPulses  = 5'(SPI_RD_PULSES);
    localparam logic [4:0] RdFirst   = 5'(SPI_RD_FIRST_SAMPLE);

    spi_state_e  state_q, state_d;
    logic [7:0]  phase_q, phase_d;
    logic [4:0]  pulse_q, pulse_d;
    logic [4:0]  target_q, target_d;
    logic [16:0] shift_q, shift_d;
    logic        rd_q, rd_d;
    logic [7:0]  rdata_q, rdata_d;

    logic        cs_q, cs_d;
    logic        sclk_q, sclk_d;
    logic        mosi_q, mosi_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [7:0]  rsp_rdata_q, rsp_rdata_d;

    logic        miso_s;
    logic [4:0]  pulse_nxt;

    spi_pwm_host_sync_2ff u_miso_sync (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .d_i    (miso),
        .q_o    (miso_s)
    );

    assign pulse_nxt = pulse_q + 5'd1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            phase_q     <= 8'd0;
            pulse_q     <= 5'd0;
            target_q    <= 5'd0;
            shift_q     <= 17'd0;
            rd_q        <= 1'b0;
            rdata_q     <= 8'd0;
            cs_q        <= 1'b1;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            pulse_q     <= pulse_d;
            target_q    <= target_d;
            shift_q     <= shift_d;
            rd_q        <= rd_d;
            rdata_q     <= rdata_d;
            cs_q        <= cs_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        pulse_d  = pulse_q;
        target_d = target_q;
        shift_d  = shift_q;
        rd_d     = rd_q;
        rdata_d  = rdata_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    state_d  = StSetup;
                    phase_d  = 8'd0;
                    pulse_d  = 5'd0;
                    target_d = cmd_write ? WrPulses : RdPulses;
                    rd_d     = !cmd_write;
                    shift_d  = build_frame(cmd_write, cmd_addr, cmd_wdata);
                    rdata_d  = 8'd0;
                end
            end
            StSetup: begin
                if (phase_q == PhaseLast) begin
                    state_d = StHigh;
                    phase_d = 8'd0;
                end else begin
                    phase_d = phase_q + 8'd1;
                end
            end
            StHigh: begin
                if (phase_q == PhaseLast) begin
                    state_d = StLow;
                    phase_d = 8'd0;
                    pulse_d = pulse_nxt;
                    shift_d = {shift_q[15:0], 1'b0};
                    if (rd_q && (pulse_nxt >= RdFirst)) begin
                        rdata_d = {rdata_q[6:0], miso_s};
                    end
                end else begin
                    phase_d = phase_q + 8'd1;
                end
            end
            StLow: begin
                if (phase_q == PhaseLast) begin
                    state_d = (pulse_q == target_q) ? StGap : StHigh;
                    phase_d = 8'd0;
                end else begin
                    phase_d = phase_q + 8'd1;
                end
            end
            StGap: begin
                if (phase_q == GapLast) begin
                    state_d = StIdle;
                    phase_d = 8'd0;
                end else begin
                    phase_d = phase_q + 8'd1;
                end
            end
            default: begin
                state_d = StIdle;
                phase_d = 8'd0;
            end
        endcase
    end

    // Outputs are registered from the next state so they change on the same
    // edge as the state they belong to.
    always_comb begin
        cs_d        = !((state_d == StSetup) || (state_d == StHigh) || (state_d == StLow));
        sclk_d      = (state_d == StHigh);
        mosi_d      = !cs_d && shift_d[16];
        ready_d     = (state_d == StIdle);
        busy_d      = (state_d != StIdle);
        rsp_valid_d = (state_d == StGap) && (state_q != StGap);
        rsp_rdata_d = rsp_rdata_q;
        if (rsp_valid_d) begin
            rsp_rdata_d = rd_q ? rdata_q : 8'h00;
        end
    end

    assign cs        = cs_q;
    assign sclk      = sclk_q;
    assign mosi      = mosi_q;
    assign cmd_ready = ready_q;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_spi_pwm_host.sv
// Self-checking bench for spi_pwm_host against a behavioural SPI PWM-driver
// model and a level scoreboard.
module tb_spi_pwm_host;
    import spi_pwm_host_pkg::*;

    localparam int D = 4;
    localparam int G = 4;

    logic       clk;
    logic       reset_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [2:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       busy;
    logic       sclk;
    logic       cs;
    logic       mosi;
    logic       miso;

    int n_cmp = 0;
    int n_err = 0;

    spi_pwm_host #(
        .CLK_DIV (D),
        .CS_GAP  (G)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .busy      (busy),
        .sclk      (sclk),
        .cs        (cs),
        .mosi      (mosi),
        .miso      (miso)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Driver model: shifts mosi on sclk rise, serves reads from pulse 9 fall,
    // commits writes on the 16th fall; clears its frame state on cs.
    logic [7:0]  s_level [8];
    logic [7:0]  ref_level [8];
    logic [16:0] s_rx;
    int          s_np;
    logic        s_rd;
    logic [7:0]  s_sh;

    initial begin
        s_rx = '0;
        s_np = 0;
        s_rd = 1'b0;
        s_sh = '0;
        miso = 1'b0;
    end

    always @(negedge cs) begin
        s_rx = '0;
        s_np = 0;
        s_rd = 1'b0;
    end

    always @(posedge cs) miso = 1'b0;

    always @(posedge sclk) begin
        if (!cs) begin
            s_rx = {s_rx[15:0], mosi};
            s_np = s_np + 1;
        end
    end

    always @(negedge sclk) begin
        if (!cs) begin
            if (s_np == 9 && !s_rx[8]) begin
                s_rd = 1'b1;
                s_sh = (s_rx[3:1] == 3'd7) ? 8'h00 : s_level[s_rx[3:1]];
                miso = s_sh[7];
            end else if (s_rd && s_np > 9 && s_np < 17) begin
                s_sh = {s_sh[6:0], 1'b0};
                miso = s_sh[7];
            end
            if (s_np == 16 && s_rx[15] && s_rx[10:8] != 3'd7) begin
                s_level[s_rx[10:8]] = s_rx[7:0];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (!cmd_ready && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk("ready_before_cmd", 32'(cmd_ready), 32'd1);
    endtask

    task automatic do_cmd(input logic wr, input logic [2:0] a, input logic [7:0] wd,
                          input bit hold);
        int          k;
        int          g;
        int          cslow;
        int          np;
        logic [15:0] exp16;
        logic [7:0]  exp_rd;
        wait_ready();
        np        = wr ? SPI_WR_PULSES : SPI_RD_PULSES;
        exp16     = {wr, 4'b0000, a, (wr ? wd : 8'h00)};
        exp_rd    = (wr || a == 3'd7) ? 8'h00 : ref_level[a];
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = wd;
        @(negedge clk);
        k = 1;
        chk("cs_low_after_accept", 32'(cs), 32'd0);
        chk("ready_low_busy", 32'({cmd_ready, busy}), 32'b01);
        if (!hold) cmd_valid = 1'b0;
        cslow = 0;
        while (k < 600) begin
            if (hold) begin
                cmd_write = 1'($urandom);
                cmd_addr  = 3'($urandom);
                cmd_wdata = 8'($urandom);
            end
            if (rsp_valid) break;
            if (!cs) cslow++;
            @(negedge clk);
            k++;
        end
        cmd_valid = 1'b0;
        chk("rsp_latency", 32'(k), 32'(1 + (2 * np + 1) * D));
        chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_rd));
        chk("cs_low_cycles", 32'(cslow), 32'((2 * np + 1) * D));
        chk("cs_high_at_rsp", 32'(cs), 32'd1);
        chk("sclk_pulses", 32'(s_np), 32'(np));
        chk("mosi_frame", 32'(s_rx), wr ? 32'({1'b0, exp16}) : 32'({exp16, 1'b0}));
        if (wr && a < 3'(PWM_NUM_CHANNELS)) ref_level[a] = wd;
        g = 0;
        @(negedge clk);
        g++;
        chk("rsp_single_pulse", 32'(rsp_valid), 32'd0);
        while (!cmd_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk("ready_gap", 32'(g), 32'(G));
        chk("rdata_held", 32'(rsp_rdata), 32'(exp_rd));
        if (wr && a < 3'(PWM_NUM_CHANNELS)) chk("driver_level", 32'(s_level[a]), 32'(wd));
    endtask

    initial begin
        int   k;
        int   seen;
        logic wr;
        logic [2:0] a;
        logic [7:0] wd;

        for (int i = 0; i < 8; i++) begin
            s_level[i]   = 8'($urandom);
            ref_level[i] = s_level[i];
        end
        s_level[5]   = 8'hA5;
        ref_level[5] = 8'hA5;
        s_level[7]   = 8'h00;
        ref_level[7] = 8'h00;

        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 3'd0;
        cmd_wdata = 8'd0;
        repeat (3) @(negedge clk);
        chk("reset_cs_sclk_mosi", 32'({cs, sclk, mosi}), 32'b100);
        chk("reset_ready_busy", 32'({cmd_ready, busy}), 32'b10);
        chk("reset_rsp", 32'({rsp_valid, rsp_rdata}), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        do_cmd(1'b1, 3'd3, 8'h80, 1'b0);
        do_cmd(1'b0, 3'd5, 8'h00, 1'b0);

        for (int i = 0; i < 7; i++) do_cmd(1'b1, 3'(i), 8'(16 * i + 1), 1'b0);
        for (int i = 0; i < 7; i++) do_cmd(1'b0, 3'(i), 8'($urandom), 1'b0);

        do_cmd(1'b1, 3'd2, 8'h3C, 1'b1);
        do_cmd(1'b0, 3'd2, 8'h00, 1'b1);

        do_cmd(1'b0, 3'd7, 8'h00, 1'b0);
        do_cmd(1'b1, 3'd7, 8'hFF, 1'b0);
        for (int i = 0; i < 7; i++) chk("addr7_no_change", 32'(s_level[i]), 32'(ref_level[i]));

        for (int n = 0; n < 20; n++) begin
            wr = 1'($urandom);
            a  = 3'($urandom);
            wd = 8'($urandom);
            do_cmd(wr, a, wd, ($urandom_range(0, 3) == 0));
        end

        // Abort a read partway through with reset.
        wait_ready();
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 3'd5;
        @(negedge clk);
        cmd_valid = 1'b0;
        k = 0;
        while (s_np < 5 && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("reached_pulse5", 32'(s_np), 32'd5);
        reset_n = 1'b0;
        @(negedge clk);
        chk("abort_cs_sclk_mosi", 32'({cs, sclk, mosi}), 32'b100);
        chk("abort_ready_busy", 32'({cmd_ready, busy}), 32'b10);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        repeat (200) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        chk("abort_no_rsp", 32'(seen), 32'd0);
        chk("abort_rdata_cleared", 32'(rsp_rdata), 32'd0);

        do_cmd(1'b0, 3'd5, 8'h00, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
